hex_display_driver: RTL and testbench
=====================================

Name: hex_display_driver

Overview:
- Parametrised multi-digit hex-to-7-segment display driver.
- Captures an N-digit hex value on a load strobe and decodes every digit to a static segment bus.
- Also drives a time-multiplexed scan port (one digit per slot) for boards with shared segment lines.
- Adds leading-zero blanking, per-digit blink and segment polarity selection; used by the status/debug display path of the simulator top level.

Parameters:
- NUM_DIGITS, 8, digits displayed; legal 1..16.
- ACTIVE_LOW, 1, 1 = segment and anode outputs driven low-on; 0 = high-on.
- SCAN_DIV, 50000, clocks per scan slot; legal >= 1.
- BLINK_DIV, 12500000, clocks per blink half-period; legal >= 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- load  in  1  single-cycle capture strobe.
- value  in  4*NUM_DIGITS  hex digits; digit i = value[4i+3:4i], digit 0 rightmost.
- lz_blank  in  1  enable leading-zero blanking; captured with load.
- blink_mask  in  NUM_DIGITS  bit i set = digit i blinks; captured with load.
- segs  out  7*NUM_DIGITS  static segments; digit i = segs[7i+6:7i], bit order {g,f,e,d,c,b,a}.
- scan_segs  out  7  segments of the digit currently scanned.
- scan_an  out  NUM_DIGITS  one-hot digit enable for the scan port.
- updated  out  1  one-cycle pulse when newly loaded data first appears on segs.

Behaviour:
- Reset (async assert, sync release by the existing reset tree):
  - Captured value = 0, lz_blank = 0, blink mask = 0.
  - scan_idx = 0, scan_cnt = 0, blink_cnt = 0, blink phase = 0 (visible).
  - segs and scan_segs all segments off: all 1s if ACTIVE_LOW, else all 0s.
  - scan_an all off; updated = 0.
- Capture: load sampled high at edge k latches value, lz_blank and blink_mask at edge k. load low leaves the capture registers unchanged.
- Latency: segs reflects the captured data at edge k+1. updated is high for exactly the cycle following edge k+1. Back-to-back loads give back-to-back updated pulses; the last load wins.
- Decode (active-high internal, {g..a}):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
  - Output = internal pattern XOR {7{ACTIVE_LOW}}.
  - Blanked digit = all segments off.
- Leading-zero blanking (lz_blank = 1): scanning from digit NUM_DIGITS-1 downward, zero digits are blanked until the first nonzero digit. Digit 0 is never blanked, so value 0 shows a single "0".
- Blink counter:
  - blink_cnt runs 0..BLINK_DIV-1 continuously; the phase toggles on wrap.
  - While phase = 1, digits with their captured mask bit set are blanked.
  - Loading does not reset blink_cnt or the phase.
  - Blink blanking ORs with leading-zero blanking.
- Scan counter:
  - scan_cnt runs 0..SCAN_DIV-1; on wrap, scan_idx advances by 1 modulo NUM_DIGITS (NUM_DIGITS-1 -> 0).
  - scan_segs and scan_an are registered from scan_idx at the same edge, so both are always consistent.
  - scan_an has exactly one bit on after the first edge following reset; all off only during reset.
- Free-running divisors: the blink and scan counters are independent of load.
- Simultaneous events: a load at a scan wrap or blink wrap edge takes effect on the following edge on both segs and scan_segs. No glitch combinations of old and new digits on the same registered cycle.
- Width rules: counters sized as clog2 of their divisor, minimum 1 bit. scan_idx is clog2(NUM_DIGITS) bits, minimum 1. No truncation warnings at NUM_DIGITS = 1.
- Reset mid-operation: all state returns to reset values immediately; an in-flight updated pulse is killed.

Test Plan:
- Reset, NUM_DIGITS=4, ACTIVE_LOW=1 -> segs=28'hFFFFFFF, scan_an=4'hF, updated=0 during reset.
- load with value=16'h12AF, lz_blank=0 at edge k -> segs at edge k+1 = {7'b1111001,7'b0100100,7'b0001000,7'b0001110}; updated high for one cycle only.
- value=16'h0030, lz_blank=1 -> digits 3,2 blanked (7'h7F), digit 1 shows "3" (7'b0110000), digit 0 shows "0" (7'b1000000). value=0 -> only digit 0 shows "0".
- SCAN_DIV=2 -> scan_an steps 1110, 1101, 1011, 0111 (ACTIVE_LOW), each held 2 cycles, then wraps to 1110; scan_segs matches the segs slice of the enabled digit each cycle.
- BLINK_DIV=8, blink_mask=4'b0010 -> digit 1 alternates between its pattern and 7'h7F every 8 cycles; other digits steady. Reload mid-period does not shift the phase.
- Assert reset_n low mid-scan, one cycle after a load -> outputs return to reset values asynchronously with no updated pulse; after release, scanning restarts at digit 0.

Source files
------------

// File: rtl/hex_display_driver.sv
// Multi-digit hex to 7-segment driver with a static bus and a scanned port.
// Supports leading-zero blanking, per-digit blink and selectable polarity.
module hex_display_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int ACTIVE_LOW = 1,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 12500000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    lz_blank,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7*NUM_DIGITS-1:0] segs,
  output logic [6:0]              scan_segs,
  output logic [NUM_DIGITS-1:0]   scan_an,
  output logic                    updated
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic          POL       = (ACTIVE_LOW != 0);

  logic [4*NUM_DIGITS-1:0] val_q;
  logic                    lz_q;
  logic [NUM_DIGITS-1:0]   mask_q;
  logic                    load_q;

  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] scan_idx;
  logic [BW-1:0] blink_cnt;
  logic          phase;

  logic [7*NUM_DIGITS-1:0] segs_nxt;
  logic [6:0]              scan_sel;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic                    seen;
  logic                    blank;
  logic [3:0]              dig;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] p;
    unique case (d)
      4'h0: p = 7'b0111111;
      4'h1: p = 7'b0000110;
      4'h2: p = 7'b1011011;
      4'h3: p = 7'b1001111;
      4'h4: p = 7'b1100110;
      4'h5: p = 7'b1101101;
      4'h6: p = 7'b1111101;
      4'h7: p = 7'b0000111;
      4'h8: p = 7'b1111111;
      4'h9: p = 7'b1101111;
      4'hA: p = 7'b1110111;
      4'hB: p = 7'b1111100;
      4'hC: p = 7'b0111001;
      4'hD: p = 7'b1011110;
      4'hE: p = 7'b1111001;
      default: p = 7'b1110001;
    endcase
    return p;
  endfunction

  // Walk from the most significant digit; blanking stops at first nonzero.
  always_comb begin
    seen     = 1'b0;
    blank    = 1'b0;
    dig      = '0;
    segs_nxt = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      dig   = val_q[4*i +: 4];
      blank = (lz_q && !seen && (dig == 4'h0) && (i != 0))
            || (phase && mask_q[i]);
      seen  = seen | (dig != 4'h0);
      segs_nxt[7*i +: 7] = blank ? {7{POL}} : (hex7(dig) ^ {7{POL}});
    end
  end

  always_comb begin
    scan_sel = '0;
    an_nxt   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == scan_idx) begin
        scan_sel  = segs_nxt[7*i +: 7];
        an_nxt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_q   <= '0;
      lz_q    <= 1'b0;
      mask_q  <= '0;
      load_q  <= 1'b0;
      updated <= 1'b0;
    end else begin
      if (load) begin
        val_q  <= value;
        lz_q   <= lz_blank;
        mask_q <= blink_mask;
      end
      load_q  <= load;
      updated <= load_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      segs      <= {(7*NUM_DIGITS){POL}};
      scan_segs <= {7{POL}};
      scan_an   <= {NUM_DIGITS{POL}};
    end else begin
      segs      <= segs_nxt;
      scan_segs <= scan_sel;
      scan_an   <= an_nxt ^ {NUM_DIGITS{POL}};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_MAX) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_MAX) ? '0 : scan_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hex_display_driver.sv
// Bench for hex_display_driver: directed steps plus random loads,
// checked against an arithmetic model of digits, blink and scan timing.
module tb_hex_display_driver;

  localparam int ND = 4;
  localparam int SD = 2;
  localparam int BD = 8;

  localparam logic [6:0] PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        lz_blank = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic [27:0] segs;
  logic [6:0]  scan_segs;
  logic [3:0]  scan_an;
  logic        updated;

  int total = 0;
  int bad = 0;
  int n = 0;

  logic [15:0] c_val, p_val;
  logic        c_lz, p_lz;
  logic [3:0]  c_mask, p_mask;
  logic        c_ld, p_ld;

  hex_display_driver #(
    .NUM_DIGITS(ND),
    .ACTIVE_LOW(1),
    .SCAN_DIV(SD),
    .BLINK_DIV(BD)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .load(load),
    .value(value),
    .lz_blank(lz_blank),
    .blink_mask(blink_mask),
    .segs(segs),
    .scan_segs(scan_segs),
    .scan_an(scan_an),
    .updated(updated)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) n <= 0;
    else n <= n + 1;

  function automatic logic [27:0] exp_segs(
    input logic [15:0] v, input logic lz,
    input logic [3:0] m, input logic ph);
    logic [27:0] r;
    logic [3:0]  d;
    logic        blk;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      d   = 4'((v >> (4*i)) & 16'hF);
      blk = (lz && i > 0 && (v >> (4*i)) == 16'h0) || (ph && m[i]);
      r[7*i +: 7] = blk ? 7'h7F : ~PAT[d];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [27:0] es;
    logic [3:0]  ea;
    logic        ph;
    int          idx;
    ph  = (((n - 1) / BD) % 2) == 1;
    idx = ((n - 1) / SD) % ND;
    es  = exp_segs(p_val, p_lz, p_mask, ph);
    ea  = 4'b0001 << idx;
    ea  = ~ea;
    chk({tag, ".segs"}, 64'(segs), 64'(es));
    chk({tag, ".an"}, 64'(scan_an), 64'(ea));
    chk({tag, ".ss"}, 64'(scan_segs), 64'(es[7*idx +: 7]));
    chk({tag, ".upd"}, 64'(updated), 64'(p_ld));
  endtask

  task automatic step(input logic ld, input logic [15:0] v,
                      input logic lz, input logic [3:0] m);
    load = ld;
    value = v;
    lz_blank = lz;
    blink_mask = m;
    @(posedge clk);
    p_val = c_val;
    p_lz = c_lz;
    p_mask = c_mask;
    p_ld = c_ld;
    if (ld) begin
      c_val = v;
      c_lz = lz;
      c_mask = m;
    end
    c_ld = ld;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic model_reset();
    c_val = '0; c_lz = 1'b0; c_mask = '0; c_ld = 1'b0;
    p_val = '0; p_lz = 1'b0; p_mask = '0; p_ld = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.segs", 64'(segs), 64'(28'hFFFFFFF));
    chk("rst.an", 64'(scan_an), 64'(4'hF));
    chk("rst.ss", 64'(scan_segs), 64'(7'h7F));
    chk("rst.upd", 64'(updated), 64'(1'b0));
    reset_n = 1'b1;

    step(1'b0, 16'h0, 1'b0, 4'h0);
    check_all("first");
    chk("first.an1", 64'(scan_an), 64'(4'b1110));

    step(1'b1, 16'h12AF, 1'b0, 4'h0);
    check_all("ld12af");
    step(1'b0, 16'h0, 1'b0, 4'h0);
    check_all("show12af");
    chk("s12af", 64'(segs),
        64'({7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}));
    chk("upd12af", 64'(updated), 64'(1'b1));
    step(1'b0, 16'h0, 1'b0, 4'h0);
    chk("upd12af.off", 64'(updated), 64'(1'b0));

    step(1'b1, 16'h0030, 1'b1, 4'h0);
    step(1'b0, 16'h0, 1'b0, 4'h0);
    check_all("lz0030");
    chk("s0030", 64'(segs),
        64'({7'h7F, 7'h7F, 7'b0110000, 7'b1000000}));
    step(1'b1, 16'h0000, 1'b1, 4'h0);
    step(1'b0, 16'h0, 1'b0, 4'h0);
    check_all("lz0000");
    chk("s0000", 64'(segs), 64'({7'h7F, 7'h7F, 7'h7F, 7'b1000000}));

    step(1'b1, 16'h1111, 1'b0, 4'h0);
    step(1'b1, 16'h2222, 1'b0, 4'h0);
    check_all("b2b1");
    step(1'b0, 16'h0, 1'b0, 4'h0);
    check_all("b2b2");
    chk("b2b.upd", 64'(updated), 64'(1'b1));
    step(1'b0, 16'h0, 1'b0, 4'h0);
    check_all("b2b3");

    step(1'b1, 16'h5678, 1'b0, 4'b0010);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 16'h0, 1'b0, 4'h0);
      check_all("blink");
    end
    step(1'b1, 16'h9ABC, 1'b0, 4'b0010);
    check_all("blink.rl");
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 16'h0, 1'b0, 4'h0);
      check_all("blink2");
    end

    for (int i = 0; i < 300; i++) begin
      logic [15:0] rv;
      rv = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rv = rv & 16'h00FF;
      step($urandom_range(0, 2) == 0, rv,
           1'($urandom), 4'($urandom));
      check_all("rand");
    end

    step(1'b1, 16'hBEEF, 1'b0, 4'h0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid.segs", 64'(segs), 64'(28'hFFFFFFF));
    chk("mid.an", 64'(scan_an), 64'(4'hF));
    chk("mid.ss", 64'(scan_segs), 64'(7'h7F));
    chk("mid.upd", 64'(updated), 64'(1'b0));
    @(posedge clk);
    #1;
    chk("mid.upd2", 64'(updated), 64'(1'b0));
    chk("mid.segs2", 64'(segs), 64'(28'hFFFFFFF));
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    step(1'b0, 16'h0, 1'b0, 4'h0);
    check_all("post");
    chk("post.an", 64'(scan_an), 64'(4'b1110));
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 16'h0, 1'b0, 4'h0);
      check_all("post2");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
